// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: registers one access, drives a variable-latency
// SRAM-style bus, and returns one aligned, extended response per accepted request.
module lsu_mem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    input  logic                flush,
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [4:0]          resp_rd,
    output logic [2:0]          resp_exc,
    output logic [ADDR_W-1:0]   badvaddr,
    output logic                stall,
    output logic [2:0]          dbg_state
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Handshakes: a request transfers on the edge where req_valid && req_ready;
    // mem_req holds address/enables/data stable until the edge where mem_gnt is high.
    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [4:0]          rd_q, rd_d;
    logic [2:0]          exc_q, exc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   bad_q, bad_d;
    logic [15:0]         cnt_q, cnt_d;

    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

    logic              req_misal, req_illegal, cnt_expired;
    logic [OFFW-1:0]   k, bmask, lane, li;
    logic [NB-1:0]     lane_wen;
    logic [DATA_W-1:0] lane_wdata, load_mask, shifted, load_data;

    assign req_misal   = (req_addr[2:0] & size_mask(req_op[1:0])) != 3'b000;
    assign req_illegal = (req_op[1:0] == 2'd3) && (DATA_W == 32);
    assign cnt_expired = (cnt_q == 16'(TIMEOUT - 1));

    // Big-endian lowest lane is N-B-k; with k aligned to B that is ~k with the
    // in-unit offset bits cleared.
    assign k     = addr_q[OFFW-1:0];
    assign bmask = OFFW'(size_mask(op_q[1:0]));
    assign lane  = (BIG_ENDIAN != 0) ? (~k & ~bmask) : k;

    always_comb begin
        lane_wen   = '0;
        lane_wdata = '0;
        load_mask  = '0;
        li         = '0;
        for (int i = 0; i < NB; i++) begin
            li = OFFW'(i);
            if ((li & ~bmask) == lane) lane_wen[i] = 1'b1;
            if ((li & ~bmask) == '0)   load_mask[8*i +: 8] = 8'hFF;
            lane_wdata[8*i +: 8] = wdata_q[{li & bmask, 3'b000} +: 8];
        end
    end

    assign shifted   = mem_rdata >> {lane, 3'b000};
    assign load_data = (shifted & load_mask)
                     | ((!op_q[2] && shifted[{bmask, 3'b111}]) ? ~load_mask : '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        exc_d   = exc_q;
        rdata_d = rdata_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    rdata_d = '0;
                    exc_d   = 3'd0;
                    if (req_illegal) begin
                        exc_d   = 3'd4;
                        bad_d   = req_addr;
                        state_d = S_RESP;
                    end else if (req_misal) begin
                        exc_d   = req_op[3] ? 3'd2 : 3'd1;
                        bad_d   = req_addr;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    // A flushed store has already been committed to the bus; only its response is dropped.
                    if (op_q[3]) begin
                        state_d = flush ? S_IDLE : S_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = flush ? S_DRAIN : S_WAIT;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = flush ? S_IDLE : S_RESP;
                end else if (cnt_expired) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        exc_d   = 3'd3;
                        bad_d   = addr_q;
                        state_d = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: state_d = S_IDLE;
            S_DRAIN: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid || cnt_expired) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            exc_q   <= '0;
            rdata_q <= '0;
            bad_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            exc_q   <= exc_d;
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
    assign mem_wen    = (mem_req && op_q[3]) ? lane_wen : '0;
    assign mem_wdata  = mem_req ? lane_wdata : '0;
    assign resp_valid = (state_q == S_RESP) && !flush;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_rd    = resp_valid ? rd_q : '0;
    assign resp_exc   = resp_valid ? exc_q : '0;
    assign badvaddr   = bad_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised MEM-stage load/store unit. It replaces the combinational byte-mask and load-extract logic with a registered, handshaked memory port.
- Accepts one access from the EX/MEM boundary and drives a variable-latency SRAM-style bus.
- Aligns and extends load data, detects misalignment and bus timeouts, and returns one response per accepted request.
- Raises `stall` to the hazard unit while busy.

Parameters:
DATA_W, 32, bus data width; 32 or 64.
ADDR_W, 32, address width.
BIG_ENDIAN, 1, 1 means byte offset 0 maps to the most-significant lane; 0 means little-endian.
TIMEOUT, 255, maximum cycles waiting for mem_rvalid before a bus-error response; 1..65535.

Ports:
clk  in  1  clock; all flops on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  access request
req_ready  out  1  unit can accept a request
req_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size (0 byte, 1 half, 2 word, 3 dword)
req_addr  in  ADDR_W  effective address
req_wdata  in  DATA_W  store data, right-aligned
req_rd  in  5  destination register tag, passed through to the response
flush  in  1  cancel the in-flight access, suppress its response
mem_req  out  1  bus request
mem_wen  out  DATA_W/8  byte-lane write enables; all 0 for a load
mem_addr  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero)
mem_wdata  out  DATA_W  lane-replicated store data
mem_gnt  in  1  bus accepted mem_req this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  aligned, extended load data; 0 for stores and exceptions
resp_rd  out  5  tag of the completing request
resp_exc  out  3  0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout, 4 illegal size
badvaddr  out  ADDR_W  req_addr of the faulting access; held until the next exception
stall  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0 except req_ready=1; timeout counter=0.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- Request capture: req_ready=1 only in IDLE. A request is accepted on the edge where req_valid && req_ready; op, addr, wdata and rd are registered at that edge.
- Checks on accept:
  - Size 3 with DATA_W=32 -> RESP with exc 4.
  - Misaligned access (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0) -> RESP with exc 1 (load) or 2 (store). No mem_req is issued.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_addr, mem_wen and mem_wdata are driven from the registers and held stable until mem_gnt.
  - On mem_gnt: a store goes to RESP; a load goes to WAIT and clears the timeout counter.
- WAIT:
  - The counter increments each cycle.
  - mem_rvalid -> capture aligned data -> RESP.
  - Counter reaching TIMEOUT with no rvalid -> RESP with exc 3.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted in the following cycle.
- Flush:
  - In REQ before gnt -> IDLE, no response.
  - In REQ with gnt in the same cycle (load), or in WAIT -> DRAIN.
  - In RESP -> resp_valid is forced to 0.
  - In IDLE -> ignored.
- DRAIN: absorb mem_rvalid (or hit timeout), then IDLE. No response is produced.
- Lane mapping (lane i = bits 8i+7:8i; k = addr offset within the bus word; N = DATA_W/8):
  - Byte: lane N-1-k if BIG_ENDIAN, else lane k.
  - Half and word follow the same rule at their granularity.
  - Example, BIG_ENDIAN, DATA_W=32:
    - Byte at offset 0 -> wen 1000; offset 1 -> 0100; offset 2 -> 0010; offset 3 -> 0001.
    - Half at offset 0 -> 1100; half at offset 2 -> 0011.
    - Word -> 1111.
- Store data: the byte is replicated N times, the half N/2 times, the word N/4 times.
- Load data: the selected lanes are right-aligned, then sign-extended (op[2]=0) or zero-extended (op[2]=1). Word with DATA_W=64 obeys the unsigned bit; dword is never extended.
- Minimum latencies (gnt in the first REQ cycle):
  - Load with rvalid one cycle after gnt: resp_valid 3 cycles after the accept edge.
  - Store: resp_valid 2 cycles after accept.
  - Exception: resp_valid 1 cycle after accept.
- Asynchronous reset mid-access returns to IDLE immediately; any later mem_rvalid is ignored in IDLE.

Test Plan:
1. BIG_ENDIAN=1, DATA_W=32: SB addr=0x1001, wdata=0x000000A5, gnt immediate -> mem_wen=0100, mem_wdata=0xA5A5A5A5, mem_addr=0x1000; resp_valid 2 cycles after accept with exc=0.
2. LB addr=0x2003, rdata=0x11223380 -> resp_rdata=0xFFFFFF80; same with LBU -> 0x00000080; LH addr=0x2002 -> 0x00003380.
3. LW addr=0x3002 -> no mem_req; resp_valid next cycle with exc=1 and badvaddr=0x3002. SH addr=0x3001 -> exc=2.
4. TIMEOUT=4, load granted with no rvalid -> resp_valid with exc=3 after the 4th WAIT cycle; stall high throughout, low after RESP.
5. Flush in WAIT, rvalid 3 cycles later -> no resp_valid, req_ready returns the cycle after rvalid. Flush in REQ before gnt -> IDLE next cycle, mem_req drops.
6. DATA_W=64, BIG_ENDIAN=0: LW addr=0x4004, rdata=0x8000000012345678 -> resp_rdata=0xFFFFFFFF80000000. With DATA_W=32, size 3 -> exc=4.
